// File: rtl/traffic_light_pkg.sv
// Shared types for the traffic light monitor: light patterns,
// phase encoding, monitor FSM states and error-flag bit indices.
package traffic_light_pkg;

  // Bus bit order: [3]=Left [2]=Green [1]=Yellow [0]=Red
  localparam logic [3:0] TL_RED = 4'b0001;
  localparam logic [3:0] TL_LG  = 4'b1000;
  localparam logic [3:0] TL_LY  = 4'b1010;
  localparam logic [3:0] TL_SG  = 4'b0100;
  localparam logic [3:0] TL_SY  = 4'b0010;

  typedef enum logic [2:0] {
    NS_LG, NS_LY, NS_SG, NS_SY,
    EW_LG, EW_LY, EW_SG, EW_SY
  } phase_e;

  typedef enum logic {
    SYNC,
    TRACK
  } mon_state_e;

  localparam int ERR_CONFLICT = 0;
  localparam int ERR_ILLEGAL  = 1;
  localparam int ERR_ORDER    = 2;
  localparam int ERR_TIMING   = 3;

  // {valid, index} of a non-red pair pattern within a half-cycle
  function automatic logic [2:0] pat_decode(
    input logic [3:0] p
  );
    logic [2:0] r;
    r = 3'b000;
    unique case (p)
      TL_LG:   r = 3'b100;
      TL_LY:   r = 3'b101;
      TL_SG:   r = 3'b110;
      TL_SY:   r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tl_phase_decoder.sv
// Combinational decode of the four light buses into a phase.
// Ports: north/south/east/west_tl in; legal, conflict, pair_mismatch, phase out.
module tl_phase_decoder
  import traffic_light_pkg::*;
(
  input  logic [3:0] north_tl,
  input  logic [3:0] south_tl,
  input  logic [3:0] east_tl,
  input  logic [3:0] west_tl,
  output logic       legal,
  output logic       conflict,
  output logic       pair_mismatch,
  output phase_e     phase
);

  logic [2:0] ns_d;
  logic [2:0] ew_d;

  assign pair_mismatch = (north_tl != south_tl)
                      || (east_tl != west_tl);
  assign conflict = (north_tl != TL_RED)
                 && (east_tl != TL_RED);

  always_comb begin
    ns_d  = pat_decode(north_tl);
    ew_d  = pat_decode(east_tl);
    legal = 1'b0;
    phase = NS_LG;
    if (!pair_mismatch) begin
      if (east_tl == TL_RED && ns_d[2]) begin
        legal = 1'b1;
        phase = phase_e'({1'b0, ns_d[1:0]});
      end else if (north_tl == TL_RED && ew_d[2]) begin
        legal = 1'b1;
        phase = phase_e'({1'b1, ew_d[1:0]});
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of intersection light order, dwell and conflicts.
// Ports: clk, reset (sync, active-low), north/south/east/west_tl in;
//   phase, locked, err_pulse, err_flags {timing,order,illegal,conflict},
//   cycle_count out. Macro TL_MON_CYCLE_CNT_EN builds the cycle counter.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int LEFT_TIME   = 5,
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  north_tl,
  input  logic [3:0]  south_tl,
  input  logic [3:0]  east_tl,
  input  logic [3:0]  west_tl,
  output logic [2:0]  phase,
  output logic        locked,
  output logic        err_pulse,
  output logic [3:0]  err_flags,
  output logic [15:0] cycle_count
);

  if (LEFT_TIME < 1 || LEFT_TIME > 254 ||
      GREEN_TIME < 1 || GREEN_TIME > 254 ||
      YELLOW_TIME < 1 || YELLOW_TIME > 254) begin : g_bad_param
    $error("traffic_light_monitor: dwell params must be 1..254");
  end

  function automatic logic [7:0] req_dwell(
    input logic [2:0] p
  );
    logic [7:0] r;
    unique case (p[1:0])
      2'd0:    r = 8'(LEFT_TIME);
      2'd2:    r = 8'(GREEN_TIME);
      default: r = 8'(YELLOW_TIME);
    endcase
    return r;
  endfunction

  logic       dec_legal;
  logic       dec_conflict;
  logic       dec_mismatch;
  phase_e     dec_phase;

  mon_state_e state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] dwell_q, dwell_d;
  logic       qual_q, qual_d;
  logic [3:0] flags_q;
  logic       pulse_q;
  logic [3:0] err_d;
  logic       held;
  logic [7:0] req;

  tl_phase_decoder u_dec (
    .north_tl      (north_tl),
    .south_tl      (south_tl),
    .east_tl       (east_tl),
    .west_tl       (west_tl),
    .legal         (dec_legal),
    .conflict      (dec_conflict),
    .pair_mismatch (dec_mismatch),
    .phase         (dec_phase)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SYNC;
      phase_q <= '0;
      dwell_q <= '0;
      qual_q  <= 1'b0;
      flags_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      qual_q  <= qual_d;
      flags_q <= flags_q | err_d;
      pulse_q <= |err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:  if (dec_legal) state_d = TRACK;
      TRACK: if (|err_d) state_d = SYNC;
    endcase
  end

  // Error priority chain plus segment/dwell bookkeeping
  always_comb begin
    held    = (dec_phase == phase_q);
    req     = req_dwell(phase_q);
    err_d   = '0;
    phase_d = phase_q;
    dwell_d = dwell_q;
    qual_d  = qual_q;
    if (state_q == TRACK) begin
      if (dec_conflict)
        err_d[ERR_CONFLICT] = 1'b1;
      else if (dec_mismatch || !dec_legal)
        err_d[ERR_ILLEGAL] = 1'b1;
      else if (!held && dec_phase != phase_q + 3'd1)
        err_d[ERR_ORDER] = 1'b1;
      else if (qual_q && held && dwell_q >= req)
        err_d[ERR_TIMING] = 1'b1;
      else if (qual_q && !held && dwell_q < req)
        err_d[ERR_TIMING] = 1'b1;
    end
    unique case (state_q)
      SYNC: begin
        if (dec_legal) begin
          phase_d = dec_phase;
          dwell_d = 8'd1;
          qual_d  = 1'b0;
        end
      end
      TRACK: begin
        if (err_d == '0) begin
          if (held) begin
            if (dwell_q != 8'hFF)
              dwell_d = dwell_q + 8'd1;
          end else begin
            phase_d = dec_phase;
            dwell_d = 8'd1;
            qual_d  = 1'b1;
          end
        end
      end
    endcase
  end

`ifdef TL_MON_CYCLE_CNT_EN
  logic [15:0] cnt_q;
  logic        wrap;

  assign wrap = (state_q == TRACK) && (err_d == '0)
             && (phase_q == EW_SY) && (dec_phase == NS_LG);

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else if (wrap)
      cnt_q <= cnt_q + 16'd1;
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

  assign phase     = phase_q;
  assign locked    = (state_q == TRACK);
  assign err_pulse = pulse_q;
  assign err_flags = flags_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor (5/5/2 dwells).
// Table of single-fault vectors plus hand-written multi-cycle sequences.
module tb_traffic_light_monitor;

  localparam logic [3:0] R  = 4'b0001;
  localparam logic [3:0] LG = 4'b1000;
  localparam logic [3:0] SG = 4'b0100;
  localparam logic [3:0] XX = 4'b1111;

`ifdef TL_MON_CYCLE_CNT_EN
  localparam logic [15:0] EXP_CYC = 16'd3;
`else
  localparam logic [15:0] EXP_CYC = 16'd0;
`endif

  typedef struct packed {
    logic [2:0] phase;
    logic       locked;
    logic       pulse;
    logic [3:0] flags;
  } exp_t;

  typedef struct packed {
    logic [3:0] n;
    logic [3:0] s;
    logic [3:0] e;
    logic [3:0] w;
    exp_t       ex;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [3:0]  north_tl, south_tl, east_tl, west_tl;
  logic [2:0]  phase;
  logic        locked;
  logic        err_pulse;
  logic [3:0]  err_flags;
  logic [15:0] cycle_count;

  exp_t sb[$];
  vec_t tbl[11];
  int   n_checks = 0;
  int   n_fail   = 0;

  traffic_light_monitor #(
    .LEFT_TIME   (5),
    .GREEN_TIME  (5),
    .YELLOW_TIME (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .north_tl    (north_tl),
    .south_tl    (south_tl),
    .east_tl     (east_tl),
    .west_tl     (west_tl),
    .phase       (phase),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_flags   (err_flags),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(int p, logic lk, logic pu,
                              logic [3:0] f);
    exp_t x;
    x.phase  = 3'(p);
    x.locked = lk;
    x.pulse  = pu;
    x.flags  = f;
    return x;
  endfunction

  function automatic logic [3:0] patt(int p);
    logic [3:0] r;
    case (p % 4)
      0:       r = 4'b1000;
      1:       r = 4'b1010;
      2:       r = 4'b0100;
      default: r = 4'b0010;
    endcase
    return r;
  endfunction

  function automatic int dw(int p);
    return (p % 2 == 0) ? 5 : 2;
  endfunction

  task automatic check(input string nm);
    exp_t ex;
    exp_t act;
    ex  = sb.pop_front();
    act = {phase, locked, err_pulse, err_flags};
    n_checks++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got ph=%0d lk=%b pu=%b fl=%b, want ph=%0d lk=%b pu=%b fl=%b",
               nm, act.phase, act.locked, act.pulse, act.flags,
               ex.phase, ex.locked, ex.pulse, ex.flags);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] n, s, e, w,
                      input exp_t ex, input string nm);
    @(negedge clk);
    reset    = rst;
    north_tl = n;
    south_tl = s;
    east_tl  = e;
    west_tl  = w;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  task automatic stepp(input int p, input exp_t ex, input string nm);
    logic [3:0] ns, ew;
    ns = (p < 4) ? patt(p) : R;
    ew = (p < 4) ? R : patt(p);
    step(1'b1, ns, ns, ew, ew, ex, nm);
  endtask

  task automatic do_reset(input int p);
    logic [3:0] ns, ew;
    ns = (p < 4) ? patt(p) : R;
    ew = (p < 4) ? R : patt(p);
    step(1'b0, ns, ns, ew, ew, mk(0, 0, 0, 4'b0000), "reset");
  endtask

  task automatic check_cyc(input logic [15:0] want, input string nm);
    n_checks++;
    if (cycle_count !== want) begin
      n_fail++;
      $display("FAIL %s: got cycle_count=%0d, want %0d",
               nm, cycle_count, want);
    end
  endtask

  initial begin
    reset    = 1'b0;
    north_tl = R;
    south_tl = R;
    east_tl  = R;
    west_tl  = R;

    tbl[0]  = '{LG, LG, R,  R,  mk(0, 1, 0, 4'b0000)};
    tbl[1]  = '{4'b1010, 4'b1010, R, R, mk(1, 1, 0, 4'b0000)};
    tbl[2]  = '{SG, SG, SG, SG, mk(0, 0, 1, 4'b0001)};
    tbl[3]  = '{LG, LG, LG, LG, mk(0, 0, 1, 4'b0001)};
    tbl[4]  = '{LG, R,  R,  R,  mk(0, 0, 1, 4'b0010)};
    tbl[5]  = '{LG, LG, R,  SG, mk(0, 0, 1, 4'b0010)};
    tbl[6]  = '{R,  R,  R,  R,  mk(0, 0, 1, 4'b0010)};
    tbl[7]  = '{XX, XX, R,  R,  mk(0, 0, 1, 4'b0010)};
    tbl[8]  = '{SG, SG, R,  R,  mk(0, 0, 1, 4'b0100)};
    tbl[9]  = '{R,  R,  LG, LG, mk(0, 0, 1, 4'b0100)};
    tbl[10] = '{SG, R,  SG, SG, mk(0, 0, 1, 4'b0001)};

    // Three full model cycles, then the NS_LG that closes the third
    do_reset(0);
    check_cyc(16'd0, "reset_cycle_count");
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 8; p++)
        for (int d = 0; d < dw(p); d++)
          stepp(p, mk(p, 1, 0, 4'b0000), "model_seq");
    stepp(0, mk(0, 1, 0, 4'b0000), "model_wrap");
    check_cyc(EXP_CYC, "cycle_count_3");

    // Conflict held two cycles: single pulse, then relock
    step(1'b1, SG, SG, SG, SG, mk(0, 0, 1, 4'b0001), "conflict");
    step(1'b1, SG, SG, SG, SG, mk(0, 0, 0, 4'b0001), "conflict_hold");
    stepp(0, mk(0, 1, 0, 4'b0001), "conflict_relock");

    // Single-fault table from a fresh lock at NS_LG
    for (int i = 0; i < 11; i++) begin
      do_reset(0);
      stepp(0, mk(0, 1, 0, 4'b0000), "tbl_lock");
      step(1'b1, tbl[i].n, tbl[i].s, tbl[i].e, tbl[i].w,
           tbl[i].ex, $sformatf("tbl_%0d", i));
    end

    // Order jump NS_LG -> NS_SG, relock on SG
    do_reset(0);
    stepp(0, mk(0, 1, 0, 4'b0000), "order_lock");
    stepp(2, mk(0, 0, 1, 4'b0100), "order_jump");
    stepp(2, mk(2, 1, 0, 4'b0100), "order_relock");

    // Overrun: qualified NS_SY held 3 cycles
    do_reset(2);
    stepp(2, mk(2, 1, 0, 4'b0000), "ovr_lock");
    stepp(2, mk(2, 1, 0, 4'b0000), "ovr_sg");
    stepp(3, mk(3, 1, 0, 4'b0000), "ovr_sy1");
    stepp(3, mk(3, 1, 0, 4'b0000), "ovr_sy2");
    stepp(3, mk(3, 0, 1, 4'b1000), "ovr_sy3");
    stepp(3, mk(3, 1, 0, 4'b1000), "ovr_relock");
    for (int k = 0; k < 3; k++)
      stepp(3, mk(3, 1, 0, 4'b1000), "ovr_unqual_hold");

    // Short: qualified EW_SG held 4 cycles then EW_SY
    do_reset(5);
    stepp(5, mk(5, 1, 0, 4'b0000), "short_lock");
    for (int k = 0; k < 4; k++)
      stepp(6, mk(6, 1, 0, 4'b0000), "short_sg");
    stepp(7, mk(6, 0, 1, 4'b1000), "short_exit");

    // Short exit into a wrong phase reports order only
    do_reset(0);
    stepp(0, mk(0, 1, 0, 4'b0000), "prio_lock");
    stepp(1, mk(1, 1, 0, 4'b0000), "prio_ly");
    stepp(3, mk(1, 0, 1, 4'b0100), "prio_order");

    // Pair mismatch, then a legal sequence relocks with no new flag
    do_reset(0);
    stepp(0, mk(0, 1, 0, 4'b0000), "mis_lock");
    stepp(1, mk(1, 1, 0, 4'b0000), "mis_ly");
    step(1'b1, LG, R, R, R, mk(1, 0, 1, 4'b0010), "mismatch");
    stepp(2, mk(2, 1, 0, 4'b0010), "mis_relock");
    stepp(2, mk(2, 1, 0, 4'b0010), "mis_sg");
    stepp(3, mk(3, 1, 0, 4'b0010), "mis_sy1");
    stepp(3, mk(3, 1, 0, 4'b0010), "mis_sy2");
    stepp(4, mk(4, 1, 0, 4'b0010), "mis_ewlg");

    // Mid-run reset with sticky flags set
    do_reset(4);
    check_cyc(16'd0, "midreset_cycle_count");
    stepp(6, mk(6, 1, 0, 4'b0000), "midreset_relock");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
